scope_sample_fifo: RTL and testbench

- Upstream capture stage of the scope data path: paces ADC sampling, detects the trigger, and stores a post-trigger record of DEPTH 8-bit samples in on-chip RAM.
- Presents one sample at a time on fifo_data, which drives the 8-bit in_port of the CPU's FIFO-data PIO.
- The CPU arms a capture and steps through the record using PIO output bits (arm, rd_adv).

---
 rtl/scope_fifo_pkg.sv | 17 +
 rtl/scope_trig_detect.sv | 39 +++
 rtl/scope_sample_fifo.sv | 172 +++++++++++++++++
 tb/tb_scope_sample_fifo.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_fifo_pkg.sv
// Shared types and default sizes for the scope capture FIFO.
// Optional auto-trigger is enabled by defining SCOPE_FIFO_AUTO_TRIG_EN.
package scope_fifo_pkg;

   localparam int DEPTH_LOG2_DEF = 9;
   localparam int DATA_W_DEF     = 8;
   localparam int DIV_W_DEF      = 16;
   localparam int AUTO_W_DEF     = 20;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_TRIG,
      CAPTURE,
      DONE
   } state_e;

endpackage

// File: rtl/scope_trig_detect.sv
// Slope trigger: remembers the previous sample and flags a level crossing.
// The hit output is combinational, valid in the same cycle as the strobe.
module scope_trig_detect
   import scope_fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              strobe_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [DATA_W-1:0] level_i,
   input  logic              slope_i,
   input  logic              clear_i,
   output logic              hit_o
);

   logic [DATA_W-1:0] prev_q;
   logic              prev_valid_q;
   logic              rise, fall;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
      end else if (clear_i) begin
         prev_valid_q <= 1'b0;
      end else if (strobe_i) begin
         prev_q       <= data_i;
         prev_valid_q <= 1'b1;
      end
   end

   assign rise  = (prev_q < level_i) && (data_i >= level_i);
   assign fall  = (prev_q > level_i) && (data_i <= level_i);
   // No hit until a sample has been seen since the last clear.
   assign hit_o = strobe_i && !clear_i && prev_valid_q && (slope_i ? rise : fall);

endmodule

// File: rtl/scope_sample_fifo.sv
// Scope capture stage: sample pacing, trigger, post-trigger record and CPU readout.
// Define SCOPE_FIFO_AUTO_TRIG_EN to force a trigger after 2^AUTO_W quiet samples.
module scope_sample_fifo
   import scope_fifo_pkg::*;
#(
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int DIV_W      = DIV_W_DEF
`ifdef SCOPE_FIFO_AUTO_TRIG_EN
   ,
   parameter int AUTO_W     = AUTO_W_DEF
`endif
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] adc_data,
   input  logic [DIV_W-1:0]  sample_div,
   input  logic [DATA_W-1:0] trig_level,
   input  logic              trig_slope,
   input  logic              arm,
   input  logic              force_trig,
   input  logic              rd_adv,
   output logic              adc_sample,
   output logic [DATA_W-1:0] fifo_data,
   output logic              fifo_full,
   output logic              fifo_empty,
   output logic              trig_seen
);

   localparam int                    DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = '1;

   logic [DIV_W-1:0]      div_q;
   logic                  adc_sample_q;
   logic                  arm_q, rd_adv_q;
   logic                  arm_edge, rd_edge;
   state_e                state_q;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic                  full_q, empty_q, trig_seen_q;
   logic [DATA_W-1:0]     fifo_data_q;
   logic [DATA_W-1:0]     mem [DEPTH];

   logic                  wait_smp, cap_smp, det_hit, auto_fire, trig;
   logic                  mem_we;
   logic [DEPTH_LOG2-1:0] mem_waddr;

   // Divider: strobe on the cycle after the count hits zero, then reload.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q        <= '0;
         adc_sample_q <= 1'b0;
      end else if (div_q == '0) begin
         div_q        <= sample_div;
         adc_sample_q <= 1'b1;
      end else begin
         div_q        <= div_q - DIV_W'(1);
         adc_sample_q <= 1'b0;
      end
   end

   assign arm_edge = arm & ~arm_q;
   assign rd_edge  = rd_adv & ~rd_adv_q;

   // An arm edge swallows any sample landing in the same cycle.
   assign wait_smp = adc_sample_q && (state_q == WAIT_TRIG) && !arm_edge;
   assign cap_smp  = adc_sample_q && (state_q == CAPTURE) && !arm_edge;

   scope_trig_detect #(
      .DATA_W (DATA_W)
   ) u_trig (
      .clk      (clk),
      .reset_n  (reset_n),
      .strobe_i (wait_smp),
      .data_i   (adc_data),
      .level_i  (trig_level),
      .slope_i  (trig_slope),
      .clear_i  (arm_edge),
      .hit_o    (det_hit)
   );

`ifdef SCOPE_FIFO_AUTO_TRIG_EN
   logic [AUTO_W-1:0] auto_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         auto_q <= '0;
      else if (arm_edge)
         auto_q <= '0;
      else if (wait_smp)
         auto_q <= auto_q + AUTO_W'(1);
   end

   assign auto_fire = &auto_q;
`else
   assign auto_fire = 1'b0;
`endif

   assign trig      = wait_smp && (det_hit || force_trig || auto_fire);
   assign mem_we    = trig || cap_smp;
   assign mem_waddr = (state_q == CAPTURE) ? wr_ptr_q : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         arm_q       <= 1'b0;
         rd_adv_q    <= 1'b0;
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b0;
         trig_seen_q <= 1'b0;
      end else begin
         arm_q    <= arm;
         rd_adv_q <= rd_adv;
         if (arm_edge) begin
            state_q     <= WAIT_TRIG;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b0;
            trig_seen_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE: ;
               WAIT_TRIG:
                  if (trig) begin
                     wr_ptr_q    <= DEPTH_LOG2'(1);
                     trig_seen_q <= 1'b1;
                     state_q     <= CAPTURE;
                  end
               CAPTURE:
                  if (cap_smp) begin
                     if (wr_ptr_q == LAST_ADDR) begin
                        full_q  <= 1'b1;
                        state_q <= DONE;
                     end else begin
                        wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
                     end
                  end
               DONE:
                  // Reading the last word marks empty; the pointer stays put.
                  if (rd_edge && !empty_q) begin
                     if (rd_ptr_q == LAST_ADDR)
                        empty_q <= 1'b1;
                     else
                        rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
                  end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_waddr] <= adc_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         fifo_data_q <= '0;
      else
         fifo_data_q <= mem[rd_ptr_q];
   end

   assign adc_sample = adc_sample_q;
   assign fifo_data  = fifo_data_q;
   assign fifo_full  = full_q;
   assign fifo_empty = empty_q;
   assign trig_seen  = trig_seen_q;

endmodule

// File: tb/tb_scope_sample_fifo.sv
// Directed bench for scope_sample_fifo: pacing, triggers, readout, re-arm, reset.
// Build with SCOPE_FIFO_AUTO_TRIG_EN to exercise the auto-trigger path.
module tb_scope_sample_fifo;

   logic        clk;
   logic        reset_n;
   logic [7:0]  adc_data;
   logic [15:0] sample_div;
   logic [7:0]  trig_level;
   logic        trig_slope;
   logic        arm;
   logic        force_trig;
   logic        rd_adv;
   logic        adc_sample;
   logic [7:0]  fifo_data;
   logic        fifo_full;
   logic        fifo_empty;
   logic        trig_seen;

   int pass_cnt  = 0;
   int total_cnt = 0;

`ifdef SCOPE_FIFO_AUTO_TRIG_EN
   localparam bit AUTO_EN = 1'b1;
   scope_sample_fifo #(.AUTO_W(4)) dut (
`else
   localparam bit AUTO_EN = 1'b0;
   scope_sample_fifo dut (
`endif
      .clk        (clk),
      .reset_n    (reset_n),
      .adc_data   (adc_data),
      .sample_div (sample_div),
      .trig_level (trig_level),
      .trig_slope (trig_slope),
      .arm        (arm),
      .force_trig (force_trig),
      .rd_adv     (rd_adv),
      .adc_sample (adc_sample),
      .fifo_data  (fifo_data),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty),
      .trig_seen  (trig_seen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] ramp(input int k);
      logic [7:0] r;
      r = 8'h80 + 8'(k * 8);
      return r;
   endfunction

   // Present v and return after the strobe edge that consumed it.
   task automatic push(input logic [7:0] v);
      int n;
      adc_data = v;
      n = 0;
      while (adc_sample !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         total_cnt++;
         $display("FAIL push_timeout adc_sample never rose (value %02h)", v);
      end
      @(negedge clk);
   endtask

   task automatic arm_pulse();
      arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
   endtask

   task automatic rd_pulse(output logic [7:0] mid);
      rd_adv = 1'b1;
      @(negedge clk);
      mid = fifo_data;
      rd_adv = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      total_cnt++; if (adc_sample !== 1'b0) $display("FAIL rst_adc_sample got=%0b exp=0", adc_sample); else pass_cnt++;
      total_cnt++; if (fifo_data !== 8'h00) $display("FAIL rst_fifo_data got=%02h exp=00", fifo_data); else pass_cnt++;
      total_cnt++; if (fifo_full !== 1'b0) $display("FAIL rst_full got=%0b exp=0", fifo_full); else pass_cnt++;
      total_cnt++; if (fifo_empty !== 1'b0) $display("FAIL rst_empty got=%0b exp=0", fifo_empty); else pass_cnt++;
      total_cnt++; if (trig_seen !== 1'b0) $display("FAIL rst_trig_seen got=%0b exp=0", trig_seen); else pass_cnt++;
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_divider();
      int n;
      sample_div = 16'd3;
      n = 0;
      @(negedge clk);
      while (adc_sample !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         total_cnt++;
         if (adc_sample !== ((i % 4) == 0))
            $display("FAIL div3_strobe cycle %0d got=%0b exp=%0b", i, adc_sample, (i % 4) == 0);
         else pass_cnt++;
      end
      sample_div = 16'd0;
      n = 0;
      @(negedge clk);
      while (adc_sample !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         total_cnt++;
         if (adc_sample !== 1'b1) $display("FAIL div0_strobe cycle %0d got=%0b exp=1", i, adc_sample);
         else pass_cnt++;
      end
   endtask

   task automatic test_rising();
      trig_level = 8'h80;
      trig_slope = 1'b1;
      adc_data   = 8'h00;
      arm_pulse();
      push(8'h70);
      push(8'h78);
      total_cnt++; if (trig_seen !== 1'b0) $display("FAIL rise_early_trig got=%0b exp=0", trig_seen); else pass_cnt++;
      push(8'h80);
      total_cnt++; if (trig_seen !== 1'b1) $display("FAIL rise_trig got=%0b exp=1", trig_seen); else pass_cnt++;
      for (int k = 1; k <= 510; k++) push(ramp(k));
      total_cnt++; if (fifo_full !== 1'b0) $display("FAIL rise_full_511 got=%0b exp=0", fifo_full); else pass_cnt++;
      push(ramp(511));
      total_cnt++; if (fifo_full !== 1'b1) $display("FAIL rise_full_512 got=%0b exp=1", fifo_full); else pass_cnt++;
      total_cnt++; if (fifo_empty !== 1'b0) $display("FAIL rise_done_empty got=%0b exp=0", fifo_empty); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (fifo_data !== 8'h80) $display("FAIL rise_word0 got=%02h exp=80", fifo_data); else pass_cnt++;
   endtask

   task automatic test_readout();
      logic [7:0] mid;
      for (int i = 1; i <= 511; i++) begin
         rd_pulse(mid);
         if (i == 1) begin
            total_cnt++;
            if (mid !== ramp(0)) $display("FAIL rd_latency got=%02h exp=%02h", mid, ramp(0)); else pass_cnt++;
         end
         total_cnt++;
         if (fifo_data !== ramp(i)) $display("FAIL rd_word %0d got=%02h exp=%02h", i, fifo_data, ramp(i));
         else pass_cnt++;
      end
      total_cnt++; if (fifo_empty !== 1'b0) $display("FAIL rd_empty_511 got=%0b exp=0", fifo_empty); else pass_cnt++;
      rd_pulse(mid);
      total_cnt++; if (fifo_empty !== 1'b1) $display("FAIL rd_empty_512 got=%0b exp=1", fifo_empty); else pass_cnt++;
      total_cnt++; if (fifo_data !== 8'h78) $display("FAIL rd_last got=%02h exp=78", fifo_data); else pass_cnt++;
      rd_pulse(mid);
      rd_pulse(mid);
      total_cnt++; if (fifo_data !== 8'h78) $display("FAIL rd_extra_hold got=%02h exp=78", fifo_data); else pass_cnt++;
      total_cnt++; if (fifo_empty !== 1'b1) $display("FAIL rd_extra_empty got=%0b exp=1", fifo_empty); else pass_cnt++;
   endtask

   task automatic test_falling();
      logic [7:0] mid;
      trig_slope = 1'b0;
      trig_level = 8'h80;
      adc_data   = 8'h00;
      arm_pulse();
      total_cnt++; if (fifo_full !== 1'b0) $display("FAIL rearm_full got=%0b exp=0", fifo_full); else pass_cnt++;
      total_cnt++; if (trig_seen !== 1'b0) $display("FAIL rearm_trig got=%0b exp=0", trig_seen); else pass_cnt++;
      total_cnt++; if (fifo_empty !== 1'b0) $display("FAIL rearm_empty got=%0b exp=0", fifo_empty); else pass_cnt++;
      push(8'h10);
      total_cnt++; if (trig_seen !== 1'b0) $display("FAIL fall_first got=%0b exp=0", trig_seen); else pass_cnt++;
      push(8'h90);
      total_cnt++; if (trig_seen !== 1'b0) $display("FAIL fall_90 got=%0b exp=0", trig_seen); else pass_cnt++;
      push(8'h70);
      total_cnt++; if (trig_seen !== 1'b1) $display("FAIL fall_70 got=%0b exp=1", trig_seen); else pass_cnt++;
      for (int k = 1; k <= 509; k++) push(8'h55);
      total_cnt++; if (fifo_full !== 1'b0) $display("FAIL fall_full_510 got=%0b exp=0", fifo_full); else pass_cnt++;
      // rd_adv during capture must be ignored; its two cycles store the last two words.
      rd_pulse(mid);
      total_cnt++; if (fifo_full !== 1'b1) $display("FAIL fall_full_512 got=%0b exp=1", fifo_full); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (fifo_data !== 8'h70) $display("FAIL fall_word0 got=%02h exp=70", fifo_data); else pass_cnt++;
      rd_pulse(mid);
      total_cnt++; if (fifo_data !== 8'h55) $display("FAIL fall_word1 got=%02h exp=55", fifo_data); else pass_cnt++;
   endtask

   task automatic test_auto_trig();
      adc_data = 8'h00;
      arm_pulse();
      for (int k = 1; k <= 15; k++) push(8'h00);
      total_cnt++; if (trig_seen !== 1'b0) $display("FAIL auto_15 got=%0b exp=0", trig_seen); else pass_cnt++;
      push(8'h00);
      total_cnt++; if (trig_seen !== AUTO_EN) $display("FAIL auto_16 got=%0b exp=%0b", trig_seen, AUTO_EN); else pass_cnt++;
      for (int k = 1; k <= 20; k++) push(8'h00);
      total_cnt++; if (trig_seen !== AUTO_EN) $display("FAIL auto_36 got=%0b exp=%0b", trig_seen, AUTO_EN); else pass_cnt++;
   endtask

   task automatic test_reset_mid_capture();
      logic [7:0] mid;
      adc_data = 8'h00;
      arm_pulse();
      force_trig = 1'b1;
      push(8'h00);
      force_trig = 1'b0;
      total_cnt++; if (trig_seen !== 1'b1) $display("FAIL force_first got=%0b exp=1", trig_seen); else pass_cnt++;
      for (int k = 1; k <= 10; k++) push(8'(k));
      reset_n = 1'b0;
      #1;
      total_cnt++; if (trig_seen !== 1'b0) $display("FAIL midrst_trig got=%0b exp=0", trig_seen); else pass_cnt++;
      total_cnt++; if (adc_sample !== 1'b0) $display("FAIL midrst_sample got=%0b exp=0", adc_sample); else pass_cnt++;
      total_cnt++; if (fifo_full !== 1'b0) $display("FAIL midrst_full got=%0b exp=0", fifo_full); else pass_cnt++;
      total_cnt++; if (fifo_data !== 8'h00) $display("FAIL midrst_data got=%02h exp=00", fifo_data); else pass_cnt++;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      arm_pulse();
      total_cnt++; if (trig_seen !== 1'b0) $display("FAIL clean_arm_trig got=%0b exp=0", trig_seen); else pass_cnt++;
      force_trig = 1'b1;
      push(8'hA0);
      force_trig = 1'b0;
      for (int k = 1; k <= 511; k++) push(8'(k));
      total_cnt++; if (fifo_full !== 1'b1) $display("FAIL clean_full got=%0b exp=1", fifo_full); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (fifo_data !== 8'hA0) $display("FAIL clean_word0 got=%02h exp=a0", fifo_data); else pass_cnt++;
      rd_pulse(mid);
      total_cnt++; if (fifo_data !== 8'h01) $display("FAIL clean_word1 got=%02h exp=01", fifo_data); else pass_cnt++;
   endtask

   initial begin
      adc_data   = 8'h00;
      sample_div = 16'd0;
      trig_level = 8'h80;
      trig_slope = 1'b1;
      arm        = 1'b0;
      force_trig = 1'b0;
      rd_adv     = 1'b0;
      test_reset();
      test_divider();
      test_rising();
      test_readout();
      test_falling();
      test_auto_trig();
      test_reset_mid_capture();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
